// File: rtl/ps2_pkg.sv
// PS/2 keyboard protocol constants, FSM encoding and event packing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam logic [7:0] PS2_ST_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ST_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ST_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ST_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ST_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ST_ERR1   = 8'hFF;

  localparam int EVT_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic       held;
  } ps2_last_make_t;

  // Keyboard replies that carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_ST_BAT_OK) || (b == PS2_ST_ACK) || (b == PS2_ST_RESEND) ||
           (b == PS2_ST_ECHO) || (b == PS2_ST_ERR0) || (b == PS2_ST_ERR1);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO with occupancy level and drop indication.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: a push while full is accepted only if the head pops in the same cycle, else dropped.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;

  logic empty, full, do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == LW'(DEPTH));
  assign do_pop  = pop_rdy & ~empty;
  assign do_push = push_vld & (~full | do_pop);
  assign drop    = push_vld & full & ~do_pop;

  // Pointer, count and storage update; pointers wrap naturally at a power-of-2 depth.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
  end

  // State registers; reset empties the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Head is forced to zero when empty so stale entries never leak out.
  assign head_vld = ~empty;
  assign head_dat = empty ? '0 : mem_q[rd_q];
  assign level    = cnt_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code folder: E0/F0 prefixes -> key events, status filter, prefix timeout, event FIFO.
// Latency: completing byte in cycle N -> evt_valid in cycle N+1 (empty FIFO).
// Backpressure: evt_valid/evt_ready; events arriving while full are dropped and flag overflow.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses repeated make events of a held key.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int ERR_W       = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          in_parity_ok,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [ERR_W-1:0]              err_count,
  output logic [7:0]                    kbd_status
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_e        state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [7:0]        stat_q, stat_d;
  logic              ovf_q, ovf_d;
  logic              cand_vld;
  ps2_evt_t          cand;
  logic              push_vld;
  logic              drop;
  logic [EVT_W-1:0]  head_dat;
  ps2_evt_t          head;

  // Prefix FSM, status capture, parity error count and stall timeout.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    stat_d   = stat_q;
    cand_vld = 1'b0;
    cand     = '0;
    if (in_valid) begin
      tmo_d = '0;
      if (!in_parity_ok) begin
        state_d = IDLE;
        if (err_q != '1) err_d = err_q + ERR_W'(1);
      end else begin
        case (state_q)
          IDLE: begin
            if (in_data == PS2_EXT)      state_d = EXT;
            else if (in_data == PS2_BRK) state_d = BRK;
            else if (is_status(in_data)) stat_d = in_data;
            else begin
              cand_vld = 1'b1;
              cand     = '{ext: 1'b0, brk: 1'b0, code: in_data};
            end
          end
          EXT: begin
            if (in_data == PS2_BRK)      state_d = EXT_BRK;
            else if (in_data != PS2_EXT) begin
              state_d  = IDLE;
              cand_vld = 1'b1;
              cand     = '{ext: 1'b1, brk: 1'b0, code: in_data};
            end
          end
          BRK: begin
            // A second prefix after F0 is a protocol error and is simply dropped.
            state_d = IDLE;
            if (in_data != PS2_EXT && in_data != PS2_BRK) begin
              cand_vld = 1'b1;
              cand     = '{ext: 1'b0, brk: 1'b1, code: in_data};
            end
          end
          default: begin
            state_d = IDLE;
            if (in_data != PS2_EXT && in_data != PS2_BRK) begin
              cand_vld = 1'b1;
              cand     = '{ext: 1'b1, brk: 1'b1, code: in_data};
            end
          end
        endcase
      end
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  ps2_last_make_t lm_q, lm_d;

  // Typematic filter: drop repeats of the held make code until its break arrives.
  always_comb begin
    lm_d     = lm_q;
    push_vld = cand_vld;
    if (cand_vld) begin
      if (!cand.brk) begin
        if (lm_q.held && lm_q.ext == cand.ext && lm_q.code == cand.code) begin
          push_vld = 1'b0;
        end else begin
          lm_d = '{ext: cand.ext, code: cand.code, held: 1'b1};
        end
      end else if (lm_q.ext == cand.ext && lm_q.code == cand.code) begin
        lm_d.held = 1'b0;
      end
    end
  end

  // Last-make register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lm_q <= '0;
    else       lm_q <= lm_d;
  end
`else
  assign push_vld = cand_vld;
`endif

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Controller state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      err_q   <= '0;
      stat_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      stat_q  <= stat_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (cand),
    .pop_rdy  (evt_ready),
    .head_vld (evt_valid),
    .head_dat (head_dat),
    .level    (fifo_level),
    .drop     (drop)
  );

  assign head       = ps2_evt_t'(head_dat);
  assign evt_code   = head.code;
  assign evt_ext    = head.ext;
  assign evt_break  = head.brk;
  assign overflow   = ovf_q;
  assign err_count  = err_q;
  assign kbd_status = stat_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: prefix folding, status/parity filtering, timeout, FIFO limits.
// Runs with FIFO_DEPTH=8, TIMEOUT_CYC=16, ERR_W=2 so saturation and timeout are reachable.
// Expectations follow PS2_TYPEMATIC_FILTER_EN when the bench is built with it defined.
module tb_ps2_kbd_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_parity_ok = 1'b1;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic [1:0] err_count;
  logic [7:0] kbd_status;

  int n_chk  = 0;
  int n_fail = 0;

  ps2_kbd_ctrl #(
    .FIFO_DEPTH  (8),
    .TIMEOUT_CYC (16),
    .ERR_W       (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_parity_ok (in_parity_ok),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_break    (evt_break),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .err_count    (err_count),
    .kbd_status   (kbd_status)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns 1 time unit after the sampling edge.
  task automatic send(input logic [7:0] b, input logic par);
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = b; in_parity_ok = par;
    @(posedge clock); #1;
    in_valid = 1'b0; in_parity_ok = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Check the head event, then pop it.
  task automatic pop_chk(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    check({tag, "_vld"}, evt_valid, 1'b1);
    check({tag, "_code"}, evt_code, code);
    check({tag, "_ext"}, evt_ext, ext);
    check({tag, "_brk"}, evt_break, brk);
    evt_ready = 1'b1;
    @(posedge clock); #1;
    evt_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_vld", evt_valid, 1'b0);
    check("rst_level", fifo_level, 4'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_err", err_count, 2'd0);
    check("rst_status", kbd_status, 8'h00);
    check("rst_code", {evt_ext, evt_break, evt_code}, 10'h000);

    // Plain make, then break; one-cycle latency into an empty FIFO
    send(8'h1C, 1'b1);
    check("make_latency", evt_valid, 1'b1);
    check("make_level", fifo_level, 4'd1);
    send(8'hF0, 1'b1);
    check("brk_prefix_level", fifo_level, 4'd1);
    send(8'h1C, 1'b1);
    check("brk_level", fifo_level, 4'd2);
    pop_chk("ev_make", 8'h1C, 1'b0, 1'b0);
    pop_chk("ev_break", 8'h1C, 1'b0, 1'b1);
    check("drained1", fifo_level, 4'd0);

    // Extended make and extended break
    send(8'hE0, 1'b1);
    send(8'h75, 1'b1);
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    check("ext_prefix_level", fifo_level, 4'd1);
    send(8'h75, 1'b1);
    check("ext_level", fifo_level, 4'd2);
    pop_chk("ev_ext_make", 8'h75, 1'b1, 1'b0);
    pop_chk("ev_ext_brk", 8'h75, 1'b1, 1'b1);

    // Status byte and parity error (also aborts a pending E0)
    send(8'hAA, 1'b1);
    check("status_noevt", fifo_level, 4'd0);
    check("status_val", kbd_status, 8'hAA);
    send(8'hE0, 1'b1);
    send(8'h1C, 1'b0);
    check("par_noevt", fifo_level, 4'd0);
    check("par_err1", err_count, 2'd1);
    send(8'h75, 1'b1);
    pop_chk("ev_after_par", 8'h75, 1'b0, 1'b0);

    // Timeout of a stalled E0; a short gap keeps the prefix alive
    send(8'hE0, 1'b1);
    idle(20);
    send(8'h1C, 1'b1);
    pop_chk("ev_timeout", 8'h1C, 1'b0, 1'b0);
    check("tmo_err_same", err_count, 2'd1);
    send(8'hE0, 1'b1);
    idle(8);
    send(8'h1C, 1'b1);
    pop_chk("ev_no_timeout", 8'h1C, 1'b1, 1'b0);

    // Error counter saturates at all-ones
    send(8'h33, 1'b0);
    send(8'h33, 1'b0);
    check("err_3", err_count, 2'd3);
    send(8'h33, 1'b0);
    check("err_sat", err_count, 2'd3);
    check("err_noevt", fifo_level, 4'd0);

    // Overflow: nine makes into eight entries
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1'b1);
    check("full_level", fifo_level, 4'd8);
    check("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk("drain_a", 8'h10 + 8'(i), 1'b0, 1'b0);
    check("drained_a", fifo_level, 4'd0);
    check("ovf_sticky", overflow, 1'b1);
    @(posedge clock); #1 ovf_clr = 1'b1;
    @(posedge clock); #1 ovf_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);

    // Push with simultaneous pop while full; clear loses to a same-cycle drop
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b1);
    check("full2_level", fifo_level, 4'd8);
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = 8'h28; evt_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; evt_ready = 1'b0;
    check("pushpop_level", fifo_level, 4'd8);
    check("pushpop_ovf", overflow, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = 8'h29; ovf_clr = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; ovf_clr = 1'b0;
    check("drop_beats_clr", overflow, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk("drain_b", 8'h21 + 8'(i), 1'b0, 1'b0);
    check("drained_b", fifo_level, 4'd0);

    // Typematic repeats
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b1);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("typ_level", fifo_level, 4'd3);
    pop_chk("typ0", 8'h1C, 1'b0, 1'b0);
    pop_chk("typ1", 8'h1C, 1'b0, 1'b1);
    pop_chk("typ2", 8'h1C, 1'b0, 1'b0);
`else
    check("typ_level", fifo_level, 4'd5);
    pop_chk("typ0", 8'h1C, 1'b0, 1'b0);
    pop_chk("typ1", 8'h1C, 1'b0, 1'b0);
    pop_chk("typ2", 8'h1C, 1'b0, 1'b0);
    pop_chk("typ3", 8'h1C, 1'b0, 1'b1);
    pop_chk("typ4", 8'h1C, 1'b0, 1'b0);
`endif
    check("typ_drained", fifo_level, 4'd0);

    // Reset mid-sequence drops the FIFO contents and the pending prefix
    send(8'h44, 1'b1);
    send(8'hE0, 1'b1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("mid_rst_level", fifo_level, 4'd0);
    check("mid_rst_vld", evt_valid, 1'b0);
    check("mid_rst_err", err_count, 2'd0);
    check("mid_rst_status", kbd_status, 8'h00);
    send(8'h1C, 1'b1);
    pop_chk("ev_after_rst", 8'h1C, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
